// File: rtl/acc_pkg.sv
// -----------------------------------------------------------------------------
// acc_pkg
// Shared definitions for the accumulator datapath:
//   - default widths and reset values for PC / SP
//   - ALU operation encodings as driven by the {op1,op2} strobes
//   - bit positions of carry / zero inside the flag byte placed on the bus
// -----------------------------------------------------------------------------
package acc_pkg;

    localparam int          DATA_W_DEF  = 8;
    localparam int          ADDR_W_DEF  = 16;
    localparam logic [15:0] PC_INIT_DEF = 16'h0000;
    localparam logic [15:0] SP_INIT_DEF = 16'hFFFF;

    // Encoding matches the raw {op1,op2} strobe pair from the sequencer.
    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_ADD  = 2'b01,
        OP_AND  = 2'b10,
        OP_SUB  = 2'b11
    } alu_op_e;

    // Flag byte layout: {0..0, carry, zero}
    localparam int FLAG_ZERO_BIT  = 0;
    localparam int FLAG_CARRY_BIT = 1;

endpackage

// File: rtl/acc_datapath_alu_unit.sv
// -----------------------------------------------------------------------------
// alu_unit
// Combinational ALU plus a one-bit logical right shifter.
// Ports:
//   i_a, i_b   operands (AC, MD)
//   i_op       operation select (pass B, add, and, subtract)
//   i_shr      shift A right by one; overrides i_op
//   o_result   DATA_W result
//   o_cout     carry-out (add), borrow (sub), shifted-out bit (shr), else 0
//   o_zero     o_result == 0
// -----------------------------------------------------------------------------
module alu_unit
    import acc_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_op_e           i_op,
    input  logic              i_shr,
    output logic [DATA_W-1:0] o_result,
    output logic              o_cout,
    output logic              o_zero
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // Both computed one bit wider; the top bit is carry-out / borrow.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = '0;
        o_cout   = 1'b0;
        if (i_shr) begin
            o_result = {1'b0, i_a[DATA_W-1:1]};
            o_cout   = i_a[0];
        end else begin
            case (i_op)
                OP_PASS: o_result = i_b;
                OP_ADD: begin
                    o_result = w_sum[DATA_W-1:0];
                    o_cout   = w_sum[DATA_W];
                end
                OP_AND:  o_result = i_a & i_b;
                OP_SUB: begin
                    o_result = w_diff[DATA_W-1:0];
                    o_cout   = w_diff[DATA_W];
                end
                default: o_result = '0;
            endcase
        end
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/acc_datapath.sv
// -----------------------------------------------------------------------------
// acc_datapath
// Register/ALU datapath driven by T-state control strobes from the instruction
// sequencers. Holds PC, SP, MA (MAH:MAL), AC, MD, carry and zero.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   enpca/enmaa/enspa       select PC / MA / SP onto mem_addr (that priority)
//   incpc/incsp/decsp       PC+1, SP+1, SP-1
//   lmah/lmal/lmd/lac       load MA high/low, MD, AC from the internal bus
//   endes/enfld             ALU result / flag byte onto the internal bus
//   op1, op2, sd0           ALU op select; sd0 = shift right (overrides)
//   scz                     flag source: 1 = ALU, 0 = bus bits [1:0]
//   lcarry/lzero            load carry / zero
//   mr_n/mw_n               memory read / write strobes (active low)
//   mem_rdata               memory read data
//   mem_addr/mem_wdata      address bus / internal bus value
//   mem_rd_n/mem_wr_n       strobes to memory
//   ac, md, carry, zero     register observability
//   md_zero, ac_gt_md       branch conditions back to the sequencer
//   bus_conflict            sticky protocol-error flag, cleared by reset only
// -----------------------------------------------------------------------------
module acc_datapath
    import acc_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] PC_INIT = ADDR_W'(PC_INIT_DEF),
    parameter logic [ADDR_W-1:0] SP_INIT = ADDR_W'(SP_INIT_DEF)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enpca,
    input  logic              enmaa,
    input  logic              enspa,
    input  logic              incpc,
    input  logic              incsp,
    input  logic              decsp,
    input  logic              lmah,
    input  logic              lmal,
    input  logic              lmd,
    input  logic              lac,
    input  logic              endes,
    input  logic              enfld,
    input  logic              op1,
    input  logic              op2,
    input  logic              sd0,
    input  logic              scz,
    input  logic              lcarry,
    input  logic              lzero,
    input  logic              mr_n,
    input  logic              mw_n,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_n,
    output logic              mem_wr_n,
    output logic [DATA_W-1:0] ac,
    output logic [DATA_W-1:0] md,
    output logic              carry,
    output logic              zero,
    output logic              md_zero,
    output logic              ac_gt_md,
    output logic              bus_conflict
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_sp;
    logic [DATA_W-1:0] r_mah;
    logic [DATA_W-1:0] r_mal;
    logic [DATA_W-1:0] r_ac;
    logic [DATA_W-1:0] r_md;
    logic              r_carry;
    logic              r_zero;
    logic              r_bus_conflict;

    logic [ADDR_W-1:0] w_ma;
    logic [DATA_W-1:0] w_bus;
    logic [DATA_W-1:0] w_flag_byte;
    logic [DATA_W-1:0] w_alu_result;
    logic              w_alu_cout;
    logic              w_alu_zero;
    logic              w_addr_conflict;
    logic              w_sp_conflict;
    logic              w_mem_conflict;

    assign w_ma = ADDR_W'({r_mah, r_mal});

    // ------------------------------------------------------------------ ALU
    alu_unit #(
        .DATA_W (DATA_W)
    ) u_alu (
        .i_a      (r_ac),
        .i_b      (r_md),
        .i_op     (alu_op_e'({op1, op2})),
        .i_shr    (sd0),
        .o_result (w_alu_result),
        .o_cout   (w_alu_cout),
        .o_zero   (w_alu_zero)
    );

    // ------------------------------------------------------------ address mux
    always_comb begin
        if (enpca)      mem_addr = r_pc;
        else if (enmaa) mem_addr = w_ma;
        else if (enspa) mem_addr = r_sp;
        else            mem_addr = '0;
    end

    // ----------------------------------------------------------- internal bus
    always_comb begin
        w_flag_byte                 = '0;
        w_flag_byte[FLAG_CARRY_BIT] = r_carry;
        w_flag_byte[FLAG_ZERO_BIT]  = r_zero;
    end

    // Memory read data has top priority so a read cycle always lands the
    // fetched byte regardless of other bus sources left asserted.
    always_comb begin
        if (!mr_n)      w_bus = mem_rdata;
        else if (enfld) w_bus = w_flag_byte;
        else if (endes) w_bus = w_alu_result;
        else            w_bus = '0;
    end

    assign mem_wdata = w_bus;

    // --------------------------------------------------------------- strobes
    // Reset holds both strobes inactive; a simultaneous read+write request
    // keeps the read and suppresses the write.
    assign mem_rd_n = mr_n | reset;
    assign mem_wr_n = mw_n | ~mr_n | reset;

    // ------------------------------------------------------ conflict detect
    assign w_addr_conflict = (enpca & enmaa) | (enpca & enspa) | (enmaa & enspa);
    assign w_sp_conflict   = incsp & decsp;
    assign w_mem_conflict  = ~mr_n & ~mw_n;

    // -------------------------------------------------------------- registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc           <= PC_INIT;
            r_sp           <= SP_INIT;
            r_mah          <= '0;
            r_mal          <= '0;
            r_ac           <= '0;
            r_md           <= '0;
            r_carry        <= 1'b0;
            r_zero         <= 1'b0;
            r_bus_conflict <= 1'b0;
        end else begin
            if (incpc) r_pc <= r_pc + ADDR_W'(1);

            // Opposing SP requests cancel out and are flagged below.
            if (incsp && !decsp)      r_sp <= r_sp + ADDR_W'(1);
            else if (decsp && !incsp) r_sp <= r_sp - ADDR_W'(1);

            if (lmah) r_mah <= w_bus;
            if (lmal) r_mal <= w_bus;
            if (lac)  r_ac  <= w_bus;
            if (lmd)  r_md  <= w_bus;

            if (lcarry) r_carry <= scz ? w_alu_cout : w_bus[FLAG_CARRY_BIT];
            if (lzero)  r_zero  <= scz ? w_alu_zero : w_bus[FLAG_ZERO_BIT];

            if (w_addr_conflict || w_sp_conflict || w_mem_conflict)
                r_bus_conflict <= 1'b1;
        end
    end

    // ------------------------------------------------------------- outputs
    assign ac           = r_ac;
    assign md           = r_md;
    assign carry        = r_carry;
    assign zero         = r_zero;
    assign bus_conflict = r_bus_conflict;
    assign md_zero      = (r_md == '0);
    assign ac_gt_md     = (r_ac > r_md);

endmodule

// File: tb/tb_acc_datapath.sv
// -----------------------------------------------------------------------------
// tb_acc_datapath
// Directed bench for acc_datapath: a linear sequence of strobe patterns with
// hand-computed expected register, bus and flag values.
// -----------------------------------------------------------------------------
module tb_acc_datapath;

    logic        clock = 1'b0;
    logic        reset;
    logic        enpca, enmaa, enspa, incpc, incsp, decsp;
    logic        lmah, lmal, lmd, lac, endes, enfld;
    logic        op1, op2, sd0, scz, lcarry, lzero, mr_n, mw_n;
    logic [7:0]  mem_rdata;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_rd_n, mem_wr_n;
    logic [7:0]  ac, md;
    logic        carry, zero, md_zero, ac_gt_md, bus_conflict;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    acc_datapath dut (
        .clock        (clock),
        .reset        (reset),
        .enpca        (enpca),
        .enmaa        (enmaa),
        .enspa        (enspa),
        .incpc        (incpc),
        .incsp        (incsp),
        .decsp        (decsp),
        .lmah         (lmah),
        .lmal         (lmal),
        .lmd          (lmd),
        .lac          (lac),
        .endes        (endes),
        .enfld        (enfld),
        .op1          (op1),
        .op2          (op2),
        .sd0          (sd0),
        .scz          (scz),
        .lcarry       (lcarry),
        .lzero        (lzero),
        .mr_n         (mr_n),
        .mw_n         (mw_n),
        .mem_rdata    (mem_rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rd_n     (mem_rd_n),
        .mem_wr_n     (mem_wr_n),
        .ac           (ac),
        .md           (md),
        .carry        (carry),
        .zero         (zero),
        .md_zero      (md_zero),
        .ac_gt_md     (ac_gt_md),
        .bus_conflict (bus_conflict)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        enpca = 0; enmaa = 0; enspa = 0; incpc = 0; incsp = 0; decsp = 0;
        lmah = 0; lmal = 0; lmd = 0; lac = 0; endes = 0; enfld = 0;
        op1 = 0; op2 = 0; sd0 = 0; scz = 0; lcarry = 0; lzero = 0;
        mr_n = 1; mw_n = 1; mem_rdata = 8'h00;
    endtask

    // Apply the current strobes for one rising edge, then settle.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Memory read of one byte into AC or MD.
    task automatic load_ac(input logic [7:0] v);
        idle(); mr_n = 0; mem_rdata = v; lac = 1; tick(); idle(); #1;
    endtask

    task automatic load_md(input logic [7:0] v);
        idle(); mr_n = 0; mem_rdata = v; lmd = 1; tick(); idle(); #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; tick(); tick(); reset = 0; #1;
    endtask

    initial begin
        idle();
        reset = 1;
        @(negedge clock);

        // ---- 1: reset state
        do_reset();
        $display("step 1: reset / idle");
        chk("rst_addr_idle", 32'(mem_addr), 32'h0000);
        chk("rst_rd_n", 32'(mem_rd_n), 32'h1);
        chk("rst_wr_n", 32'(mem_wr_n), 32'h1);
        chk("rst_ac", 32'(ac), 32'h00);
        chk("rst_md", 32'(md), 32'h00);
        chk("rst_flags", 32'({carry, zero, bus_conflict}), 32'h0);
        chk("rst_md_zero", 32'(md_zero), 32'h1);
        chk("rst_ac_gt_md", 32'(ac_gt_md), 32'h0);
        enpca = 1; #1;
        chk("rst_pc", 32'(mem_addr), 32'h0000);
        idle(); enspa = 1; #1;
        chk("rst_sp", 32'(mem_addr), 32'hFFFF);

        // Reset must override strobes in the same cycle.
        idle(); reset = 1; mr_n = 0; mw_n = 0; mem_rdata = 8'hAA; lac = 1; #1;
        chk("rst_hold_rd_n", 32'(mem_rd_n), 32'h1);
        chk("rst_hold_wr_n", 32'(mem_wr_n), 32'h1);
        tick();
        chk("rst_override_ac", 32'(ac), 32'h00);
        chk("rst_override_conf", 32'(bus_conflict), 32'h0);
        reset = 0; idle(); #1;

        // ---- 2: fetch address bytes via PC into MA
        $display("step 2: fetch 12/34 into MA");
        idle(); enpca = 1; mr_n = 0; mem_rdata = 8'h12; #1;
        chk("fetch_rd_n", 32'(mem_rd_n), 32'h0);
        chk("fetch_wdata", 32'(mem_wdata), 32'h12);
        tick();
        lmah = 1; tick();
        idle(); incpc = 1; tick();
        idle(); enpca = 1; mr_n = 0; mem_rdata = 8'h34; tick();
        lmal = 1; tick();
        idle(); incpc = 1; tick();
        idle(); enmaa = 1; #1;
        chk("ma_addr", 32'(mem_addr), 32'h1234);
        idle(); enpca = 1; #1;
        chk("pc_after_2", 32'(mem_addr), 32'h0002);

        // ---- 3: subtract / compare
        $display("step 3: AC-MD and compares");
        load_ac(8'h20);
        load_md(8'h07);
        chk("gt_20_07", 32'(ac_gt_md), 32'h1);
        op1 = 1; op2 = 1; endes = 1; lac = 1; scz = 1; lcarry = 1; lzero = 1; #1;
        chk("sub_bus", 32'(mem_wdata), 32'h19);
        tick(); idle(); #1;
        chk("sub_ac", 32'(ac), 32'h19);
        chk("sub_carry", 32'(carry), 32'h0);
        chk("sub_zero", 32'(zero), 32'h0);
        chk("gt_19_07", 32'(ac_gt_md), 32'h1);
        load_md(8'h25);
        chk("gt_19_25", 32'(ac_gt_md), 32'h0);
        load_ac(8'h05);
        load_md(8'h07);
        op1 = 1; op2 = 1; endes = 1; lac = 1; scz = 1; lcarry = 1; lzero = 1;
        tick(); idle(); #1;
        chk("borrow_ac", 32'(ac), 32'hFE);
        chk("borrow_carry", 32'(carry), 32'h1);
        // FE + 02 = 100: result wraps to zero with carry out.
        load_md(8'h02);
        op1 = 0; op2 = 1; endes = 1; lac = 1; scz = 1; lcarry = 1; lzero = 1;
        tick(); idle(); #1;
        chk("add_ac", 32'(ac), 32'h00);
        chk("add_cz", 32'({carry, zero}), 32'h3);

        // ---- 4: PUSH / POP flags
        $display("step 4: push/pop flags");
        idle(); mr_n = 0; mem_rdata = 8'h02; scz = 0; lcarry = 1; lzero = 1;
        tick(); idle(); #1;
        chk("flags_set_cz", 32'({carry, zero}), 32'h2);
        enspa = 1; enfld = 1; mw_n = 0; #1;
        chk("push_addr", 32'(mem_addr), 32'hFFFF);
        chk("push_wdata", 32'(mem_wdata), 32'h02);
        chk("push_wr_n", 32'(mem_wr_n), 32'h0);
        chk("push_rd_n", 32'(mem_rd_n), 32'h1);
        tick();
        idle(); decsp = 1; tick();
        idle(); enspa = 1; #1;
        chk("sp_dec", 32'(mem_addr), 32'hFFFE);
        mr_n = 0; mem_rdata = 8'h01; scz = 0; lcarry = 1; lzero = 1;
        tick(); idle(); #1;
        chk("pop_cz", 32'({carry, zero}), 32'h1);

        // ---- 5: shift right, AND/PASS, md_zero
        $display("step 5: shift and logic ops");
        load_ac(8'h81);
        sd0 = 1; op1 = 1; op2 = 1; endes = 1; lac = 1; scz = 1; lcarry = 1;
        tick(); idle(); #1;
        chk("shr_ac", 32'(ac), 32'h40);
        chk("shr_carry", 32'(carry), 32'h1);
        load_md(8'hC3);
        op1 = 1; op2 = 0; endes = 1; #1;
        chk("and_bus", 32'(mem_wdata), 32'h40);
        op1 = 0; op2 = 0; #1;
        chk("pass_bus", 32'(mem_wdata), 32'hC3);
        load_md(8'h00);
        chk("md_zero", 32'(md_zero), 32'h1);
        chk("no_conflict_yet", 32'(bus_conflict), 32'h0);

        // ---- 6: protocol conflicts
        $display("step 6: conflicts");
        idle(); enpca = 1; enspa = 1; #1;
        chk("conf_addr_prio", 32'(mem_addr), 32'h0002);
        tick(); idle(); #1;
        chk("conf_addr_flag", 32'(bus_conflict), 32'h1);
        do_reset();
        chk("conf_clear1", 32'(bus_conflict), 32'h0);
        mr_n = 0; mw_n = 0; #1;
        chk("conf_wr_blocked", 32'(mem_wr_n), 32'h1);
        chk("conf_rd_kept", 32'(mem_rd_n), 32'h0);
        tick(); idle(); #1;
        chk("conf_mem_flag", 32'(bus_conflict), 32'h1);
        do_reset();
        incsp = 1; decsp = 1; tick(); idle(); #1;
        chk("conf_sp_flag", 32'(bus_conflict), 32'h1);
        enspa = 1; #1;
        chk("conf_sp_hold", 32'(mem_addr), 32'hFFFF);
        idle(); incsp = 1; tick(); idle(); enspa = 1; #1;
        chk("sp_wrap", 32'(mem_addr), 32'h0000);
        do_reset();
        chk("conf_clear2", 32'(bus_conflict), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Safety net in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/acc_datapath.md
Name: acc_datapath

Overview:
Register/ALU datapath driven by the microcoded T-state control strobes of the instruction sequencers (DIV, MUL, PUSH/POP, etc.).
- Holds PC, SP, MA (MAH:MAL), AC, MD and the carry/zero flags.
- Drives the memory address bus and the read/write strobes.
- Returns status compares (md_zero, ac_gt_md) so the sequencer can branch.
- Sits directly downstream of the control sequencer: consumes its strobes and feeds back its branch conditions.

Parameters:
DATA_W, 8, data/register width
ADDR_W, 16, address width (MA = MAH:MAL, each DATA_W)
PC_INIT, 16'h0000, PC value after reset
SP_INIT, 16'hFFFF, SP value after reset (stack grows down)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
enpca, enmaa, enspa  in  1 each  drive PC / MA / SP onto mem_addr
incpc, incsp, decsp  in  1 each  PC+1, SP+1, SP-1
lmah, lmal  in  1 each  load MA high / low byte from internal bus
lmd, lac  in  1 each  load MD / AC from internal bus
endes  in  1  ALU result onto internal bus
enfld  in  1  flags {0..0,carry,zero} onto internal bus
op1, op2  in  1 each  ALU op select
sd0  in  1  shift-right op, overrides op1/op2
scz  in  1  flag source: 1 = ALU, 0 = internal bus bits [1:0]
lcarry, lzero  in  1 each  load carry / zero flag
mr_n, mw_n  in  1 each  memory read / write strobes, active-low
mem_rdata  in  DATA_W  memory read data
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  internal bus value (write data)
mem_rd_n, mem_wr_n  out  1 each  strobes to memory
ac, md  out  DATA_W  register observability
carry, zero  out  1 each  flags
md_zero  out  1  MD == 0
ac_gt_md  out  1  AC > MD, unsigned
bus_conflict  out  1  sticky protocol-error flag

Behaviour:
- Reset (sync, active-high) sets:
  - PC=PC_INIT, SP=SP_INIT, MA=0, AC=0, MD=0
  - carry=0, zero=0, bus_conflict=0
  - mem_rd_n=1, mem_wr_n=1
  - reset overrides every strobe in that cycle.
- All register and flag updates occur on the rising clock edge, using the strobes present in that cycle.
- mem_addr, mem_wdata, mem_rd_n, mem_wr_n, md_zero and ac_gt_md are combinational from current strobes and registers (zero-cycle latency).
- Address mux:
  - priority enpca > enmaa > enspa; none asserted -> 0.
  - more than one asserted -> set bus_conflict.
- Internal bus mux, first match wins:
  - mr_n==0 -> mem_rdata
  - enfld -> {0,carry,zero}
  - endes -> alu_out
  - otherwise 0
- ALU (combinational, DATA_W+1 result):
  - sd0=1 -> {0, AC[DATA_W-1:1]}, cout = AC[0]
  - {op1,op2}=00 -> pass MD, cout=0
  - 01 -> AC+MD, cout = carry-out
  - 11 -> AC-MD, cout = borrow (1 when AC<MD)
  - 10 -> AC & MD, cout=0
- Flags:
  - lcarry: carry <= scz ? alu cout : bus[1]
  - lzero: zero <= scz ? (alu_out==0) : bus[0]
- Registers:
  - lac: AC <= bus; lmd: MD <= bus
  - lmah: MA[15:8] <= bus; lmal: MA[7:0] <= bus
  - lac and lmd together load both from the same bus value.
- Counters:
  - incpc: PC+1, wraps FFFF->0000.
  - incsp/decsp: SP±1, modular wrap.
  - incsp and decsp together -> SP unchanged, set bus_conflict.
- Strobes:
  - mem_rd_n = mr_n; mem_wr_n = mw_n.
  - mr_n and mw_n both low -> force mem_wr_n=1 (read wins), set bus_conflict.
- bus_conflict clears only on reset.
- Multi-cycle operations carry no internal state beyond the registers, so reset mid-sequence leaves no residue.

Decomposition:
- Package acc_pkg holds:
  - ALU op encodings (OP_PASS, OP_ADD, OP_AND, OP_SUB)
  - DATA_W/ADDR_W defaults
  - PC_INIT/SP_INIT
  - flag bit positions within the flag byte
- One sub-module, alu_unit: combinational ALU plus shifter; outputs result, cout and zero.

Test Plan:
1. Reset, then idle -> PC=0000, SP=FFFF, AC=MD=0, mem_rd_n=mem_wr_n=1, mem_addr=0000.
2. enpca+mr_n=0 for 2 cycles with mem_rdata=12, lmah on the 2nd; incpc; repeat with 34 and lmal; then enmaa -> mem_addr=1234, PC=0002.
3. AC=20, MD=07, op1=op2=1, endes+lac+scz+lcarry+lzero -> AC=19, carry=0, zero=0, ac_gt_md=1; then MD=25 -> ac_gt_md=0; then AC-MD with AC=05, MD=07 -> AC=FE, carry=1.
4. PUSH flags with carry=1, zero=0: enspa+enfld+mw_n=0 -> mem_addr=FFFF, mem_wdata=02, mem_wr_n=0. Then decsp -> SP=FFFE. POP with mem_rdata=01, scz=0, lcarry+lzero -> carry=0, zero=1.
5. sd0 on AC=81 with lac+scz+lcarry -> AC=40, carry=1; MD=00 -> md_zero=1.
6. enpca+enspa together -> mem_addr=PC, bus_conflict=1. mr_n=mw_n=0 -> mem_wr_n=1. incsp+decsp -> SP unchanged. Reset -> bus_conflict=0.
